// File: rtl/sn_to_binary_decoder_pkg.sv
// Shared types and helpers for the stochastic-to-binary decoder.
package sn_dec_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Default window exponent and the matching counter width.
    localparam int LEN_LOG2 = 27;
    localparam int CW       = LEN_LOG2 + 1;

    // Effective window exponent.
    // A zero exponent becomes 1, and anything above max_k saturates at max_k.
    function automatic logic [31:0] clamp_k(input logic [31:0] win,
                                            input logic [31:0] max_k);
        logic [31:0] k;
        if (win == 32'd0) begin
            k = 32'd1;
        end else if (win > max_k) begin
            k = max_k;
        end else begin
            k = win;
        end
        return k;
    endfunction

endpackage

// File: rtl/sn_to_binary_decoder_if.sv
// Control, bitstream and result handshake bundle of the decoder.
// master = driver/consumer side, slave = decoder side.
interface sn_to_binary_decoder_if #(
    parameter int KW = 5,
    parameter int CW = 28
);
    logic          start;
    logic [KW-1:0] win_log2;
    logic          abort;
    logic          sn_valid;
    logic          sn_bit;
    logic          gen_restart;
    logic          busy;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] result;
    logic [CW-1:0] result_frac;

    modport master (
        output start, win_log2, abort, sn_valid, sn_bit, out_ready,
        input  gen_restart, busy, out_valid, result, result_frac
    );

    modport slave (
        input  start, win_log2, abort, sn_valid, sn_bit, out_ready,
        output gen_restart, busy, out_valid, result, result_frac
    );
endinterface

// File: rtl/sn_frac_align.sv
// Left barrel shift that turns a ones-count over a 2^k window into a fraction
// left-aligned to the full 2^LEN_LOG2 scale. Purely combinational; the parent
// registers the output.
module sn_frac_align #(
    parameter int W  = 28,
    parameter int SW = 5
) (
    input  logic [W-1:0]  count,
    input  logic [SW-1:0] shamt,
    output logic [W-1:0]  frac
);

    assign frac = count << shamt;

endmodule

// File: rtl/sn_to_binary_decoder.sv
// Counts ones in a unipolar stochastic bitstream over a window of 2^k valid
// bits and returns the raw count plus a left-aligned fraction. A one-cycle
// gen_restart pulse at window start realigns the upstream generator.
module sn_to_binary_decoder
    import sn_dec_pkg::*;
#(
    parameter int LEN_LOG2 = 27,
    parameter int KW       = 5
) (
    input  logic                   clk,
    input  logic                   reset_n,
    sn_to_binary_decoder_if.slave  bus
);

    localparam int CNT_W = LEN_LOG2 + 1;
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    state_t             state_r,       state_nxt;
    logic [KW-1:0]      k_r,           k_nxt;
    logic [CNT_W-1:0]   bit_cnt_r,     bit_cnt_nxt;
    logic [CNT_W-1:0]   ones_cnt_r,    ones_cnt_nxt;
    logic               gen_restart_r, gen_restart_nxt;
    logic               busy_r,        busy_nxt;
    logic               out_valid_r,   out_valid_nxt;
    logic [CNT_W-1:0]   result_r,      result_nxt;
    logic [CNT_W-1:0]   frac_r,        frac_nxt;

    logic [CNT_W-1:0]   sum_s;
    logic [CNT_W-1:0]   last_idx_s;
    logic [KW-1:0]      shamt_s;
    logic [CNT_W-1:0]   frac_s;

    // Count including the bit presented this cycle. Because the counters are
    // CNT_W wide, an all-ones window reaches 2^k without wrapping.
    assign sum_s      = ones_cnt_r + {{(CNT_W-1){1'b0}}, bus.sn_bit};
    assign last_idx_s = (ONE_C << k_r) - ONE_C;
    assign shamt_s    = KW'(LEN_LOG2) - k_r;

    sn_frac_align #(
        .W  (CNT_W),
        .SW (KW)
    ) u_align (
        .count (sum_s),
        .shamt (shamt_s),
        .frac  (frac_s)
    );

    // Next-state and next-output logic; every register holds by default.
    always_comb begin
        state_nxt       = state_r;
        k_nxt           = k_r;
        bit_cnt_nxt     = bit_cnt_r;
        ones_cnt_nxt    = ones_cnt_r;
        gen_restart_nxt = 1'b0;
        busy_nxt        = busy_r;
        out_valid_nxt   = out_valid_r;
        result_nxt      = result_r;
        frac_nxt        = frac_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    k_nxt           = KW'(clamp_k(32'(bus.win_log2), 32'(LEN_LOG2)));
                    bit_cnt_nxt     = '0;
                    ones_cnt_nxt    = '0;
                    gen_restart_nxt = 1'b1;
                    busy_nxt        = 1'b1;
                    state_nxt       = ACCUM;
                end else begin
                    state_nxt = IDLE;
                end
            end
            ACCUM: begin
                // Abort wins over a terminal bit arriving in the same cycle.
                if (bus.abort) begin
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else if (bus.sn_valid) begin
                    bit_cnt_nxt  = bit_cnt_r + ONE_C;
                    ones_cnt_nxt = sum_s;
                    if (bit_cnt_r == last_idx_s) begin
                        result_nxt    = sum_s;
                        frac_nxt      = frac_s;
                        out_valid_nxt = 1'b1;
                        state_nxt     = HOLD;
                    end else begin
                        state_nxt = ACCUM;
                    end
                end else begin
                    state_nxt = ACCUM;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    out_valid_nxt = 1'b0;
                    busy_nxt      = 1'b0;
                    state_nxt     = IDLE;
                end else begin
                    state_nxt = HOLD;
                end
            end
            default: begin
                busy_nxt      = 1'b0;
                out_valid_nxt = 1'b0;
                state_nxt     = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Counter, latched-exponent and output registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            k_r           <= '0;
            bit_cnt_r     <= '0;
            ones_cnt_r    <= '0;
            gen_restart_r <= 1'b0;
            busy_r        <= 1'b0;
            out_valid_r   <= 1'b0;
            result_r      <= '0;
            frac_r        <= '0;
        end else begin
            k_r           <= k_nxt;
            bit_cnt_r     <= bit_cnt_nxt;
            ones_cnt_r    <= ones_cnt_nxt;
            gen_restart_r <= gen_restart_nxt;
            busy_r        <= busy_nxt;
            out_valid_r   <= out_valid_nxt;
            result_r      <= result_nxt;
            frac_r        <= frac_nxt;
        end
    end

    assign bus.gen_restart = gen_restart_r;
    assign bus.busy        = busy_r;
    assign bus.out_valid   = out_valid_r;
    assign bus.result      = result_r;
    assign bus.result_frac = frac_r;

endmodule
